// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 opcodes, T-state ring encoding and control-word bit ordering.
// The control-word ordering is also consumed by the datapath top level.
package sap1_pkg;
    localparam int OP_W = 4;
    localparam int T_W  = 6;
    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_JMP = 4'b0011;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;
    localparam int T1_I = 0;
    localparam int T2_I = 1;
    localparam int T3_I = 2;
    localparam int T4_I = 3;
    localparam int T5_I = 4;
    localparam int T6_I = 5;
    localparam int CW_CE = 0;
    localparam int CW_CO = 1;
    localparam int CW_LM = 2;
    localparam int CW_RO = 3;
    localparam int CW_II = 4;
    localparam int CW_IO = 5;
    localparam int CW_AI = 6;
    localparam int CW_AO = 7;
    localparam int CW_SU = 8;
    localparam int CW_EO = 9;
    localparam int CW_BI = 10;
    localparam int CW_OI = 11;
    localparam int CW_J  = 12;
    localparam int CW_W  = 13;
    typedef logic [CW_W-1:0] cw_t;
    localparam cw_t M_CE = cw_t'(1) << CW_CE;
    localparam cw_t M_CO = cw_t'(1) << CW_CO;
    localparam cw_t M_LM = cw_t'(1) << CW_LM;
    localparam cw_t M_RO = cw_t'(1) << CW_RO;
    localparam cw_t M_II = cw_t'(1) << CW_II;
    localparam cw_t M_IO = cw_t'(1) << CW_IO;
    localparam cw_t M_AI = cw_t'(1) << CW_AI;
    localparam cw_t M_AO = cw_t'(1) << CW_AO;
    localparam cw_t M_SU = cw_t'(1) << CW_SU;
    localparam cw_t M_EO = cw_t'(1) << CW_EO;
    localparam cw_t M_BI = cw_t'(1) << CW_BI;
    localparam cw_t M_OI = cw_t'(1) << CW_OI;
    localparam cw_t M_J  = cw_t'(1) << CW_J;
    typedef enum logic [T_W-1:0] {
        HALTED = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } ring_t;
endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// sap1_ctrl_if: opcode in, control word and T-state ring out of the SAP-1 controller.
interface sap1_ctrl_if;
    import sap1_pkg::*;
    logic [OP_W-1:0] opcode;
    logic CE, CO, LM, RO, II, IO, AI, AO, SU, EO, BI, OI, J, HLT;
    logic [T_W-1:0] t_state;
    modport master (input opcode,
                    output CE, CO, LM, RO, II, IO, AI, AO, SU, EO, BI, OI, J, HLT, t_state);
    modport slave  (output opcode,
                    input CE, CO, LM, RO, II, IO, AI, AO, SU, EO, BI, OI, J, HLT, t_state);
endinterface

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: six-state one-hot T-cycle ring; halt parks it in the all-zero HALTED state.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           halt,
    output logic [T_W-1:0] t_state
);
    ring_t state, state_nx;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= T1;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = (halt || state == HALTED) ? HALTED : ring_t'({state[T_W-2:0], state[T_W-1]});
    end
    assign t_state = state;
endmodule

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 control unit, decodes ring position and opcode into the control word.
// Define SAP1_JMP_EN to decode opcode 0011 as JMP; otherwise it is a NOP and J is tied low.
module sap1_controller_sequencer
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    sap1_ctrl_if.master bus
);
    logic [T_W-1:0]  ts;
    logic [OP_W-1:0] op;
    logic            is_alu, hlt_t4;
    cw_t             cw, cw_t4, cw_t5, cw_t6;
    assign op     = bus.opcode;
    assign is_alu = op == OP_ADD || op == OP_SUB;
    assign hlt_t4 = ts[T4_I] && op == OP_HLT;
    sap1_ring_counter u_ring (
        .clk     (clk),
        .reset_n (reset_n),
        .halt    (hlt_t4),
        .t_state (ts)
    );
    always_comb begin
        cw_t4 = (op == OP_LDA || is_alu) ? (M_IO | M_LM) : op == OP_OUT ? (M_AO | M_OI) : '0;
`ifdef SAP1_JMP_EN
        if (op == OP_JMP) cw_t4 = M_IO | M_J;
`endif
        cw_t5 = op == OP_LDA ? (M_RO | M_AI) : is_alu ? (M_RO | M_BI) : '0;
        cw_t6 = is_alu ? (M_EO | M_AI | (op == OP_SUB ? M_SU : '0)) : '0;
        cw    = ts[T1_I] ? (M_CO | M_LM) :
                ts[T2_I] ? M_CE :
                ts[T3_I] ? (M_RO | M_II) :
                ts[T4_I] ? cw_t4 :
                ts[T5_I] ? cw_t5 :
                ts[T6_I] ? cw_t6 : '0;
    end
    // an all-zero ring means HALTED, which keeps HLT high until reset
    assign bus.HLT     = ts == '0 || hlt_t4;
    assign bus.t_state = ts;
    assign bus.CE = cw[CW_CE];
    assign bus.CO = cw[CW_CO];
    assign bus.LM = cw[CW_LM];
    assign bus.RO = cw[CW_RO];
    assign bus.II = cw[CW_II];
    assign bus.IO = cw[CW_IO];
    assign bus.AI = cw[CW_AI];
    assign bus.AO = cw[CW_AO];
    assign bus.SU = cw[CW_SU];
    assign bus.EO = cw[CW_EO];
    assign bus.BI = cw[CW_BI];
    assign bus.OI = cw[CW_OI];
    assign bus.J  = cw[CW_J];
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb_sap1_controller_sequencer: table vectors, random instructions vs. a step/halt model, reset and halt corners.
module tb_sap1_controller_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sap1_ctrl_if bus ();
    sap1_controller_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef SAP1_JMP_EN
    localparam bit JMP = 1'b1;
`else
    localparam bit JMP = 1'b0;
`endif
    localparam logic [13:0] X_CE  = 14'd1 << 0;
    localparam logic [13:0] X_CO  = 14'd1 << 1;
    localparam logic [13:0] X_LM  = 14'd1 << 2;
    localparam logic [13:0] X_RO  = 14'd1 << 3;
    localparam logic [13:0] X_II  = 14'd1 << 4;
    localparam logic [13:0] X_IO  = 14'd1 << 5;
    localparam logic [13:0] X_AI  = 14'd1 << 6;
    localparam logic [13:0] X_AO  = 14'd1 << 7;
    localparam logic [13:0] X_SU  = 14'd1 << 8;
    localparam logic [13:0] X_EO  = 14'd1 << 9;
    localparam logic [13:0] X_BI  = 14'd1 << 10;
    localparam logic [13:0] X_OI  = 14'd1 << 11;
    localparam logic [13:0] X_J   = 14'd1 << 12;
    localparam logic [13:0] X_HLT = 14'd1 << 13;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  ts;
        logic [13:0] cw;
    } vec_t;
    vec_t vt[$];

    int checks = 0;
    int errors = 0;
    int mstep;
    bit mhalt;

    function automatic logic [13:0] act();
        return {bus.HLT, bus.J, bus.OI, bus.BI, bus.EO, bus.SU, bus.AO, bus.AI,
                bus.IO, bus.II, bus.RO, bus.LM, bus.CO, bus.CE};
    endfunction

    // instruction-level model: position in the 6-step instruction plus a halted flag
    function automatic logic [13:0] model_cw(logic [3:0] op);
        if (mhalt) return X_HLT;
        case (mstep)
            0: return X_CO | X_LM;
            1: return X_CE;
            2: return X_RO | X_II;
            3: case (op)
                   4'h0, 4'h1, 4'h2: return X_IO | X_LM;
                   4'he: return X_AO | X_OI;
                   4'hf: return X_HLT;
                   4'h3: return JMP ? (X_IO | X_J) : 14'd0;
                   default: return 14'd0;
               endcase
            4: case (op)
                   4'h0: return X_RO | X_AI;
                   4'h1, 4'h2: return X_RO | X_BI;
                   default: return 14'd0;
               endcase
            default: case (op)
                   4'h1: return X_EO | X_AI;
                   4'h2: return X_EO | X_AI | X_SU;
                   default: return 14'd0;
               endcase
        endcase
    endfunction

    function automatic logic [5:0] model_ts();
        return mhalt ? 6'b0 : 6'(1 << mstep);
    endfunction

    task automatic cmp(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic check_now(input string tag, input logic [5:0] ets, input logic [13:0] ecw);
        cmp({tag, "_tstate"}, 32'(bus.t_state), 32'(ets));
        cmp({tag, "_cw"}, 32'(act()), 32'(ecw));
        cmp({tag, "_onedriver"}, 32'($countones({bus.CO, bus.RO, bus.IO, bus.AO, bus.EO}) <= 1), 32'd1);
    endtask

    task automatic adv(input logic [3:0] op);
        if (!mhalt) begin
            if (mstep == 3 && op == 4'hf) mhalt = 1'b1;
            else mstep = (mstep + 1) % 6;
        end
    endtask

    task automatic tick(input string tag, input logic [3:0] op);
        bus.opcode = op;
        #1;
        check_now(tag, model_ts(), model_cw(op));
        adv(op);
        @(negedge clk);
    endtask

    task automatic rst_async(input string tag);
        #3 reset_n = 1'b0;
        mstep = 0;
        mhalt = 1'b0;
        #1 check_now(tag, 6'b000001, X_CO | X_LM);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] op, input int s, input logic [13:0] cw);
        vec_t v;
        v.op = op;
        v.ts = 6'(1 << s);
        v.cw = cw;
        vt.push_back(v);
    endtask

    task automatic add_instr(input logic [3:0] op, input logic [13:0] c4, input logic [13:0] c5,
                             input logic [13:0] c6);
        push(op, 0, X_CO | X_LM);
        push(op, 1, X_CE);
        push(op, 2, X_RO | X_II);
        push(op, 3, c4);
        push(op, 4, c5);
        push(op, 5, c6);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.opcode = 4'h0;
        mstep = 0;
        mhalt = 1'b0;
        add_instr(4'h0, X_IO | X_LM, X_RO | X_AI, 14'd0);
        add_instr(4'h1, X_IO | X_LM, X_RO | X_BI, X_EO | X_AI);
        add_instr(4'h2, X_IO | X_LM, X_RO | X_BI, X_EO | X_AI | X_SU);
        add_instr(4'he, X_AO | X_OI, 14'd0, 14'd0);
        add_instr(4'h5, 14'd0, 14'd0, 14'd0);
        push(4'h0, 0, X_CO | X_LM);

        repeat (2) @(negedge clk);
        #1 check_now("rst_hold", 6'b000001, X_CO | X_LM);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vt[i]) begin
            bus.opcode = vt[i].op;
            #1;
            check_now($sformatf("tbl%0d", i), vt[i].ts, vt[i].cw);
            @(negedge clk);
        end

        rst_async("rst_after_tbl");
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            for (int s = 0; s < 6; s++)
                tick("rnd", s < 3 ? 4'($urandom_range(0, 15)) : op);
        end

        for (int s = 0; s < 6; s++) tick("jmp", 4'h3);

        for (int s = 0; s < 4; s++) tick("pre_t5", 4'h1);
        rst_async("rst_mid_t5");
        for (int s = 0; s < 6; s++) tick("post_rst", 4'h0);

        for (int s = 0; s < 4; s++) tick("hlt", 4'hf);
        for (int s = 0; s < 20; s++) tick("halted", 4'($urandom_range(0, 15)));
        rst_async("rst_halted");
        for (int s = 0; s < 7; s++) tick("post_halt", 4'he);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sap1_controller_sequencer.md
# sap1_controller_sequencer

Control unit of the SAP-1 CPU, directly upstream of the program counter. It steps a six-state T-cycle ring (fetch T1–T3, execute T4–T6) and decodes the instruction register opcode into the control word. That control word drives every datapath block: program-counter increment and bus enable, MAR/RAM, IR, accumulator, B register, ALU and output register. It owns the HLT condition that stops the machine.

## Interface
- No parameters; the opcode width (4) and T-state count (6) are fixed package constants.
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  4  upper nibble of the instruction register; must be valid from T4 through T6
- CE  out  1  program counter count enable
- CO  out  1  program counter drives bus
- LM  out  1  load MAR from bus
- RO  out  1  RAM drives bus
- II  out  1  load IR from bus
- IO  out  1  IR operand nibble drives bus
- AI  out  1  load accumulator
- AO  out  1  accumulator drives bus
- SU  out  1  ALU subtract (0 = add)
- EO  out  1  ALU result drives bus
- BI  out  1  load B register
- OI  out  1  load output register
- J  out  1  program counter load from bus; tied 0 unless SAP1_JMP_EN is defined
- HLT  out  1  machine halted
- t_state  out  6  one-hot ring, bit 0 = T1, for debug and bench observation

## Operation
- All control outputs are combinational decodes of the registered ring plus `opcode`. No output registers.
- Only one bus driver (CO, RO, IO, AO, EO) may be high in any cycle. The bench asserts this.
- Fetch is opcode-independent:
  - T1: CO, LM
  - T2: CE
  - T3: RO, II
- Execute:
  - LDA 0000: T4 IO, LM; T5 RO, AI; T6 none
  - ADD 0001: T4 IO, LM; T5 RO, BI; T6 EO, AI
  - SUB 0010: T4 IO, LM; T5 RO, BI; T6 EO, AI, SU
  - OUT 1110: T4 AO, OI; T5 none; T6 none
  - HLT 1111: T4 HLT=1. The next edge enters HALTED instead of T5.
  - Any other opcode is a NOP: T4–T6 all zero, and the ring still advances.
- HALTED is a separate state with t_state = 000000. In HALTED, HLT=1 and all other outputs are 0. Only reset_n leaves HALTED.
- The ring advances one position per clock: T1→T2→…→T6→T1. Every instruction takes exactly 6 cycles, with no early termination.

## Timing
- Reset (reset_n low, asynchronous): the ring goes to T1 (t_state = 000001) immediately.
  - During and after reset, CO=1 and LM=1; all other outputs are 0 and HLT=0.
  - Reset mid-instruction abandons the instruction. No partial control word is held.
- First rising edge after reset_n rises: T1→T2.
- Opcode is sampled combinationally in T4–T6 only. Its value in T1–T3 is ignored.
- HLT timing: HLT rises in the T4 cycle of a HLT instruction and stays high from then on.
- Reset asserted while HALTED returns the block to T1 with HLT=0.

## Configuration
- SAP1_JMP_EN defined:
  - Opcode 0011 = JMP. T4 asserts IO and J; T5 and T6 are empty.
- SAP1_JMP_EN undefined:
  - 0011 is a NOP.
  - J is a constant 0 output, and the port list is unchanged.

## Structure
- sap1_pkg holds the shared definitions:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT
  - T-state index constants and the one-hot width
  - the control-word bit ordering, also consumed by the datapath top level
- Sub-module sap1_ring_counter contains:
  - the 6-bit one-hot ring with asynchronous active-low reset
  - a halt input that forces and holds the all-zero HALTED encoding
- The decode stays in this block.

## Test plan
- Reset release, opcode=0000: t_state over 6 clocks reads 000001, 000010, 000100, 001000, 010000, 100000, then 000001. Control word is CO+LM, CE, RO+II, IO+LM, RO+AI, none.
- ADD then SUB, back to back: T6 of ADD gives EO=1, AI=1, SU=0. T6 of SUB gives EO=1, AI=1, SU=1. Exactly one bus driver is high in every cycle.
- OUT (1110): T4 gives AO=1 and OI=1. T5 and T6 are all zero. The ring wraps to T1.
- HLT (1111): HLT=1 in T4. Next edge gives t_state = 000000 and all outputs 0 except HLT. The state holds for 20 further clocks while opcode toggles randomly.
- reset_n pulsed low asynchronously mid-T5 and while HALTED: outputs go immediately to CO=1, LM=1, t_state = 000001, HLT=0. The next fetch proceeds normally.
- Opcode 0011 in T4: with SAP1_JMP_EN, IO=1 and J=1. Without it, all outputs are 0 and J stays 0.
